// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the slave side; the byte source / memory sit on the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a big-endian byte stream, verifies a trailing XOR
// checksum, and holds the processor in reset until a load completes cleanly.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [ADDR_W:0]   word_cnt, word_cnt_n, count_q, count_n, word_cnt_inc;
  logic [7:0]        checksum, checksum_n;
  logic [23:0]       word_buf, word_buf_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic              byte_ready_n, imem_we_n, cpu_hold_n, busy_n, done_n, error_n;
  logic              xfer, count_bad;

  assign xfer         = bus.byte_valid && bus.byte_ready;
  // Legal counts are 1 .. 2^ADDR_W; anything above that has the MSB set plus another bit.
  assign count_bad    = (word_count == '0) || (word_count[ADDR_W] && (|word_count[ADDR_W-1:0]));
  assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);

  always_comb begin
    state_n      = state;
    byte_idx_n   = byte_idx;
    word_cnt_n   = word_cnt;
    count_n      = count_q;
    checksum_n   = checksum;
    word_buf_n   = word_buf;
    imem_addr_n  = bus.imem_addr;
    imem_wdata_n = bus.imem_wdata;
    imem_we_n    = 1'b0;
    cpu_hold_n   = cpu_hold;
    busy_n       = busy;
    done_n       = done;
    error_n      = error;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          done_n     = 1'b0;
          cpu_hold_n = 1'b1;
          if (count_bad) begin
            state_n = ERR;
            error_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n     = RECV;
            count_n     = word_count;
            byte_idx_n  = '0;
            word_cnt_n  = '0;
            imem_addr_n = '0;
            checksum_n  = '0;
            busy_n      = 1'b1;
            error_n     = 1'b0;
          end
        end
      end

      RECV: begin
        if (xfer) begin
          checksum_n = checksum ^ bus.byte_data;
          byte_idx_n = byte_idx + 2'd1;
          word_buf_n = {word_buf[15:0], bus.byte_data};
          if (byte_idx == 2'd3) begin
            imem_wdata_n = {word_buf, bus.byte_data};
            imem_we_n    = 1'b1;
            state_n      = WRITE;
          end
        end
      end

      WRITE: begin
        imem_addr_n = bus.imem_addr + ADDR_W'(1);
        word_cnt_n  = word_cnt_inc;
        state_n     = (word_cnt_inc == count_q) ? CHECK : RECV;
      end

      CHECK: begin
        if (xfer) begin
          busy_n = 1'b0;
          if (bus.byte_data == checksum) begin
            state_n    = DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            state_n = ERR;
            error_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    byte_ready_n = (state_n == RECV) || (state_n == CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      byte_idx       <= '0;
      word_cnt       <= '0;
      count_q        <= '0;
      checksum       <= '0;
      word_buf       <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_n;
      byte_idx       <= byte_idx_n;
      word_cnt       <= word_cnt_n;
      count_q        <= count_n;
      checksum       <= checksum_n;
      word_buf       <= word_buf_n;
      bus.byte_ready <= byte_ready_n;
      bus.imem_we    <= imem_we_n;
      bus.imem_addr  <= imem_addr_n;
      bus.imem_wdata <= imem_wdata_n;
      cpu_hold       <= cpu_hold_n;
      busy           <= busy_n;
      done           <= done_n;
      error          <= error_n;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, continuous valid, random gaps,
// illegal counts and reset in the middle of a word.
module tb_imem_loader;
  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] word_count;
  logic       cpu_hold, busy, done, error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  prog [0:7];
  logic [7:0]  addr_log [0:15];
  logic [31:0] data_log [0:15];
  int          we_count = 0;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side scoreboard: every write pulse is logged in order.
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (we_count < 16) begin
        addr_log[we_count] <= bus.imem_addr;
        data_log[we_count] <= bus.imem_wdata;
      end
      we_count <= we_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and wait (bounded) until it is consumed.
  task automatic applyStimulus(input logic [7:0] b, input bit keep_valid);
    int waits = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && waits < 50) begin
      if (bus.imem_we === 1'b1) checkOutput("ready_low_in_write", bus.byte_ready, 0);
      @(posedge clk); #1;
      waits++;
    end
    if (bus.byte_ready !== 1'b1) checkOutput("byte_accept_timeout", bus.byte_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    if (!keep_valid) bus.byte_valid = 1'b0;
  endtask

  // mode 0: valid dropped between bytes, 1: valid held high, 2: random 0-3 cycle gaps
  task automatic run_load(input logic [7:0] csum, input int mode);
    start      = 1'b1;
    word_count = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_hold", cpu_hold, 1);
    checkOutput("start_done_clr", done, 0);
    checkOutput("start_err_clr", error, 0);
    for (int i = 0; i < 9; i++) begin
      if (mode == 2) begin
        repeat ($urandom_range(3)) begin
          @(posedge clk); #1;
        end
      end
      applyStimulus((i < 8) ? prog[i] : csum, (mode == 1) && (i < 8));
    end
  endtask

  task automatic check_words(input int base);
    checkOutput("we_pulses", we_count - base, 2);
    checkOutput("addr0", addr_log[base], 32'h0);
    checkOutput("data0", data_log[base], 32'h8C010004);
    checkOutput("addr1", addr_log[base+1], 32'h1);
    checkOutput("data1", data_log[base+1], 32'h00221820);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    checkOutput({tag, "_done"}, done, d);
    checkOutput({tag, "_error"}, error, e);
    checkOutput({tag, "_hold"}, cpu_hold, h);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ready"}, bus.byte_ready, 0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, bus.byte_ready, 0);
    checkOutput({tag, "_we"}, bus.imem_we, 0);
    checkOutput({tag, "_addr"}, bus.imem_addr, 0);
    checkOutput({tag, "_wdata"}, bus.imem_wdata, 0);
    checkOutput({tag, "_hold"}, cpu_hold, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
  endtask

  initial begin
    int base;
    prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
    prog[4] = 8'h00; prog[5] = 8'h22; prog[6] = 8'h18; prog[7] = 8'h20;
    reset          = 1'b0;
    start          = 1'b0;
    word_count     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    #1 reset = 1'b1;
    #2;
    check_reset_values("por");
    #20 reset = 1'b0;
    @(posedge clk); #1;

    // Good load, then the same stream with a wrong checksum
    base = we_count;
    run_load(8'h93, 0);
    check_words(base);
    check_status("good", 1, 0, 0);

    base = we_count;
    run_load(8'h92, 0);
    check_words(base);
    check_status("badsum", 0, 1, 1);

    // Continuous valid, then random gaps
    base = we_count;
    run_load(8'h93, 1);
    check_words(base);
    check_status("contig", 1, 0, 0);

    base = we_count;
    run_load(8'h93, 2);
    check_words(base);
    check_status("gaps", 1, 0, 0);

    // Illegal counts: zero and 2^ADDR_W + 1
    base       = we_count;
    start      = 1'b1;
    word_count = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check_status("cnt0", 0, 1, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start      = 1'b1;
    word_count = 9'd257;
    @(posedge clk); #1;
    start = 1'b0;
    check_status("cnt257", 0, 1, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("illegal_no_we", we_count - base, 0);

    // Reset asynchronously after two bytes of word 0
    base       = we_count;
    start      = 1'b1;
    word_count = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    applyStimulus(prog[0], 1'b0);
    applyStimulus(prog[1], 1'b0);
    #3 reset = 1'b1;
    #1;
    check_reset_values("midword");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midword_no_we", we_count - base, 0);

    base = we_count;
    run_load(8'h93, 0);
    check_words(base);
    check_status("restart", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The processor datapath only fetches from instruction memory; this block fills it with a program before the processor runs.
- Accepts a byte stream over a valid/ready handshake and assembles the bytes into big-endian 32-bit words.
- Writes each word to the instruction memory write port, then checks an XOR checksum byte.
- Drives cpu_hold, which the processor top uses as its reset, until a load completes cleanly.

Parameters:
- ADDR_W, 8, instruction memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load. Sampled only in IDLE, DONE or ERR.
- word_count  in  ADDR_W+1  number of words to load. Latched when start is accepted.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  holds the processor in reset while high.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded. Sticky until the next accepted start.
- error  out  1  last load failed. Sticky until the next accepted start.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0. Internal counters and the checksum register clear to 0.
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - word_count==0 or word_count>2^ADDR_W: go to ERR. error=1, done=0, cpu_hold=1.
  - Otherwise: latch word_count; clear the byte index (0..3), word counter, imem_addr and the checksum register. Go to RECV with busy=1, cpu_hold=1, done=0, error=0.
- start is ignored in RECV, WRITE and CHECK.
- RECV: byte_ready=1. A byte transfers on a cycle where byte_valid&&byte_ready.
  - Byte 0 goes to word bits [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Every accepted byte is XORed into the checksum register.
  - No transfer means no state change; there is no timeout.
- Transfer of byte 3 in cycle N: state is WRITE in cycle N+1, with imem_we=1 and imem_addr/imem_wdata holding the assembled word. byte_ready=0 in WRITE.
- Cycle after WRITE: imem_we=0, imem_addr increments, word counter increments.
  - If words written == latched count, go to CHECK; otherwise go to RECV.
  - Minimum cost is 5 cycles per word.
- imem_addr never wraps, because word_count is bounded at 2^ADDR_W. After the last word it may equal the count modulo 2^ADDR_W; memory ignores it since imem_we=0.
- CHECK: byte_ready=1. On transfer, compare the byte with the checksum register.
  - Equal: go to DONE. done=1, busy=0, cpu_hold=0.
  - Not equal: go to ERR. error=1, busy=0, cpu_hold stays 1.
- DONE/ERR hold until start. On an accepted start, cpu_hold returns to 1 in the next cycle.
- byte_ready is 0 in IDLE, WRITE, DONE and ERR. Bytes presented then are not consumed; the source must hold them.
- Reset mid-operation returns immediately to the reset values. A partially assembled word is discarded and no write is issued. Words already written stay in memory. cpu_hold=1.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> all outputs take their reset values immediately; cpu_hold=1, byte_ready=0.
- Good load: word_count=2, bytes 8C 01 00 04 00 22 18 20, checksum 0x93.
  - imem_we pulses exactly twice: addr0=0x8C010004, addr1=0x00221820.
  - Then done=1, cpu_hold=0, busy=0, error=0.
- Bad checksum: same stream with checksum 0x92 -> error=1, done=0, cpu_hold=1, busy=0; both words were still written.
- Backpressure/gaps: byte_valid held high continuously -> byte_ready=0 in every WRITE cycle and no byte is lost or duplicated. With random 0–3 cycle gaps in byte_valid -> identical memory contents.
- Illegal count: with ADDR_W=8, start with word_count=0 -> error=1. Start with word_count=257 -> error=1. No imem_we in either case.
- Reset mid-word: assert reset after 2 bytes of word 0 -> no imem_we and reset values restored. Restart with the good load -> correct result, done=1.
